cache_ctrl_nway: RTL and testbench
==================================

Name: cache_ctrl_nway

Overview:
- Parametrised N-way set-associative, read-only, word-addressed cache controller.
- Sits between a core fetch/load port (upstream) and the memory fabric.
- Generalises the fixed 4-way, 4-word-line controller to configurable ways, sets and line length.
- Adds automatic miss refill from memory, response backpressure, bulk invalidate and a selectable replacement policy.

Parameters:
- ADDR_W, 32, word address width.
- DATA_W, 32, word width.
- WAYS, 4, associativity; power of 2, ≥2.
- SETS, 32, number of sets; power of 2.
- LINE_WORDS, 4, words per line; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- uvld  in  1  upstream request valid.
- urdy  out  1  upstream request ready.
- uaddr  in  ADDR_W  word address. Field split: offset = [OFF-1:0]; index = next log2(SETS) bits; tag = the remaining upper bits.
- resp_vld  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_data  out  DATA_W  response word.
- inv  in  1  invalidate-all request (level).
- mem_req_vld  out  1  refill request valid.
- mem_req_rdy  in  1  refill request ready.
- mem_req_addr  out  ADDR_W  line-aligned refill address (offset bits zero).
- mem_resp_vld  in  1  refill beat valid; no backpressure.
- mem_resp_data  in  DATA_W  refill beat; beats arrive in ascending word order.

Behaviour:
- Storage: flop arrays for valid[SETS][WAYS], tag, data[SETS][WAYS][LINE_WORDS], repl[SETS].
- Reset: all valid=0, repl=0, state IDLE. Outputs after reset: urdy=1, resp_vld=0, resp_data=0, mem_req_vld=0, mem_req_addr=0.
- Request handshake: a request is accepted when uvld&&urdy at a clock edge; uaddr is registered into req_q.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESP, INVAL.
- IDLE: urdy=1 unless inv=1. inv has priority over uvld in the same cycle, giving IDLE→INVAL. An accepted request gives IDLE→LOOKUP.
- LOOKUP, hit (valid && tag match):
  - resp_vld=1 combinationally; resp_data = selected word. Hit latency is 1 cycle after acceptance.
  - PLRU bits update on a hit.
  - If resp_rdy=1: urdy = !inv, so a new request is accepted the same cycle (back-to-back hits, 1/cycle); next state is LOOKUP if a request was accepted, else IDLE.
  - If resp_rdy=0: go to RESP holding the data.
- LOOKUP, miss: select victim = lowest-index invalid way, else the replacement-policy way; go to MISS_REQ.
- MISS_REQ: mem_req_vld=1 with a stable line address until mem_req_rdy, then REFILL.
- REFILL:
  - Beat counter 0..LINE_WORDS-1; each mem_resp_vld writes data[idx][victim][cnt].
  - valid is cleared for the victim on entry to REFILL and set, with the new tag, after the last beat.
  - The beat whose count equals the request offset is captured as the response word.
  - After the last beat: update repl, go to RESP.
- RESP: resp_vld=1 with stable resp_data until resp_rdy; then IDLE. urdy=0.
- INVAL: clear every valid bit in one cycle, then IDLE. repl is not reset.
- Single outstanding miss; urdy=0 in MISS_REQ, REFILL, RESP and INVAL.
- mem_resp_vld outside REFILL: ignored.
- Hit on the same set as an in-flight refill: impossible (single outstanding).
- Counter wrap: the beat counter is log2(LINE_WORDS) bits; the last beat is detected at all-ones.
- Reset mid-refill: refill is abandoned; the victim stays invalid. The memory side is reset on the same rst_n.

Optional Feature:
- Macro: CACHE_CTRL_PLRU_EN.
- Defined: tree pseudo-LRU, WAYS-1 bits per set. Updated on every hit and refill to point away from the touched way; the victim follows the tree bits.
- Undefined: round-robin. repl is a log2(WAYS) counter per set, incremented on each refill into that set only; hits do not update it.
- The invalid-way-first rule applies in both modes.

Decomposition:
- Package cache_ctrl_pkg holds:
  - state enum;
  - localparams OFF_W, IDX_W, TAG_W;
  - address field extract functions;
  - PLRU victim/update functions.
- One sub-module: cache_ctrl_repl, which holds the per-set replacement state and is muxed internally by CACHE_CTRL_PLRU_EN. Inputs: idx, touch_way, touch_en, valid vector. Output: victim way.

Test Plan:
- Cold miss, default params: read 0x0FF001F0, memory returns {FF0000FF, F0F0F0F0, 00FFFF00, 00FF00FF} → one mem_req at 0x0FF001F0; resp_data=FF0000FF. A following read of 0x0FF001F2 hits, giving 00FFFF00 exactly 1 cycle after acceptance with no mem_req.
- Fill 4 tags (0FF, 0AA, 0BB, 000) into set 0x1C, then 16 interleaved reads (word offsets 0..3 × 4 tags) with resp_rdy=1 → 16 back-to-back hits at 1/cycle, correct words, no mem_req.
- Fifth tag 0x0CC001F0 into the full set:
  - PLRU_EN: the victim is the way not touched by the last access sequence; a re-read of the victim's old tag misses.
  - RR: the victim is way 0; the next eviction hits way 1.
- Backpressure: hold resp_rdy=0 for 5 cycles on a hit and on a refill → resp_vld/resp_data stable, urdy=0, single beat on release.
- inv=1 together with uvld=1 in IDLE → inv wins, request not accepted; the next read of 0x0FF001F0 misses.
- rst_n low during REFILL beat 2 → all outputs return to reset values; a subsequent read of the same line misses and refills cleanly.

Source files
------------

// File: rtl/cache_ctrl_nway_pkg.sv
// rtl/cache_ctrl_nway_pkg.sv - state codes, default field widths, address and tree-PLRU helpers
package cache_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_LOOKUP   = 3'd1;
   localparam state_t ST_MISS_REQ = 3'd2;
   localparam state_t ST_REFILL   = 3'd3;
   localparam state_t ST_RESP     = 3'd4;
   localparam state_t ST_INVAL    = 3'd5;

   localparam int OFF_W = 2;
   localparam int IDX_W = 5;
   localparam int TAG_W = 32 - OFF_W - IDX_W;

   function automatic logic [63:0] addr_off(input logic [63:0] a, input int unsigned off_w);
      return a & ((64'd1 << off_w) - 64'd1);
   endfunction

   function automatic logic [63:0] addr_idx(input logic [63:0] a, input int unsigned off_w,
                                            input int unsigned idx_w);
      return (a >> off_w) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   function automatic logic [63:0] addr_tag(input logic [63:0] a, input int unsigned off_w,
                                            input int unsigned idx_w);
      return a >> (off_w + idx_w);
   endfunction

   // Heap-ordered tree: node n (1-based) lives in bit n-1; a 0 bit steers left.
   function automatic int unsigned plru_victim(input logic [63:0] bits, input int unsigned ways);
      int unsigned node;
      node = 1;
      for (int l = 0; l < 6; l++) begin
         if (node < ways) node = 2 * node + 32'(bits[node - 1]);
      end
      return node - ways;
   endfunction

   function automatic logic [63:0] plru_update(input logic [63:0] bits, input int unsigned ways,
                                               input int unsigned way);
      logic [63:0] b;
      int unsigned node;
      b    = bits;
      node = way + ways;
      for (int l = 0; l < 6; l++) begin
         if (node > 1) begin
            b[(node >> 1) - 1] = ~node[0];
            node = node >> 1;
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/cache_ctrl_nway_if.sv
// rtl/cache_ctrl_nway_if.sv - core request/response and memory refill signal bundle
interface cache_ctrl_nway_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              uvld;
   logic              urdy;
   logic [ADDR_W-1:0] uaddr;
   logic              resp_vld;
   logic              resp_rdy;
   logic [DATA_W-1:0] resp_data;
   logic              inv;
   logic              mem_req_vld;
   logic              mem_req_rdy;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_resp_vld;
   logic [DATA_W-1:0] mem_resp_data;

   modport master (
      output uvld, uaddr, resp_rdy, inv, mem_req_rdy, mem_resp_vld, mem_resp_data,
      input  urdy, resp_vld, resp_data, mem_req_vld, mem_req_addr
   );

   modport slave (
      input  uvld, uaddr, resp_rdy, inv, mem_req_rdy, mem_resp_vld, mem_resp_data,
      output urdy, resp_vld, resp_data, mem_req_vld, mem_req_addr
   );
endinterface

// File: rtl/cache_ctrl_nway_repl.sv
// rtl/cache_ctrl_nway_repl.sv - per-set victim selection; CACHE_CTRL_PLRU_EN picks tree-PLRU, else round-robin
import cache_ctrl_pkg::*;

module cache_ctrl_repl #(
   parameter int WAYS = 4,
   parameter int SETS = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [$clog2(SETS)-1:0] idx,
   input  logic [$clog2(WAYS)-1:0] touch_way,
   input  logic                    touch_en,
   input  logic [WAYS-1:0]         valid,
   output logic [$clog2(WAYS)-1:0] victim
);
   localparam int WAY_B = $clog2(WAYS);

   logic [WAY_B-1:0] pol_victim;

`ifdef CACHE_CTRL_PLRU_EN
   logic [WAYS-2:0] plru_q [SETS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (touch_en) begin
         plru_q[idx] <= (WAYS-1)'(plru_update(64'(plru_q[idx]), WAYS, 32'(touch_way)));
      end
   end

   assign pol_victim = WAY_B'(plru_victim(64'(plru_q[idx]), WAYS));
`else
   logic [WAY_B-1:0] rr_q [SETS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (touch_en) begin
         rr_q[idx] <= rr_q[idx] + 1'b1;
      end
   end

   assign pol_victim = rr_q[idx];
`endif

   // An empty way always wins over the policy choice, lowest index first.
   always_comb begin
      victim = pol_victim;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w]) victim = WAY_B'(w);
      end
   end
endmodule

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - N-way read-only cache controller with miss refill; CACHE_CTRL_PLRU_EN selects PLRU
import cache_ctrl_pkg::*;

module cache_ctrl_nway #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int WAYS       = 4,
   parameter int SETS       = 32,
   parameter int LINE_WORDS = 4
) (
   input logic              clk,
   input logic              rst_n,
   cache_ctrl_nway_if.slave bus
);
   localparam int OFF_B = $clog2(LINE_WORDS);
   localparam int IDX_B = $clog2(SETS);
   localparam int TAG_B = ADDR_W - OFF_B - IDX_B;
   localparam int WAY_B = $clog2(WAYS);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] req_q;
   logic [WAYS-1:0]   valid_q [SETS];
   logic [TAG_B-1:0]  tag_q   [SETS][WAYS];
   logic [DATA_W-1:0] data_q  [SETS][WAYS][LINE_WORDS];
   logic [WAY_B-1:0]  victim_q, repl_victim, hit_way, touch_way;
   logic [OFF_B-1:0]  cnt_q;
   logic [DATA_W-1:0] resp_q, hit_word;
   logic [OFF_B-1:0]  req_off;
   logic [IDX_B-1:0]  req_idx;
   logic [TAG_B-1:0]  req_tag;
   logic              hit, lookup_hit, accept, fill_beat, fill_last, touch_en;

   assign req_off = OFF_B'(addr_off(64'(req_q), OFF_B));
   assign req_idx = IDX_B'(addr_idx(64'(req_q), OFF_B, IDX_B));
   assign req_tag = TAG_B'(addr_tag(64'(req_q), OFF_B, IDX_B));

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_B'(w);
         end
      end
   end

   assign hit_word   = data_q[req_idx][hit_way][req_off];
   assign lookup_hit = (state_q == ST_LOOKUP) && hit;
   assign fill_beat  = (state_q == ST_REFILL) && bus.mem_resp_vld;
   assign fill_last  = fill_beat && (&cnt_q);

   always_comb begin
      case (state_q)
         ST_IDLE:   bus.urdy = !bus.inv;
         ST_LOOKUP: bus.urdy = hit && bus.resp_rdy && !bus.inv;
         default:   bus.urdy = 1'b0;
      endcase
   end

   assign accept           = bus.uvld && bus.urdy;
   assign bus.resp_vld     = lookup_hit || (state_q == ST_RESP);
   assign bus.resp_data    = lookup_hit ? hit_word : resp_q;
   assign bus.mem_req_vld  = (state_q == ST_MISS_REQ);
   assign bus.mem_req_addr = bus.mem_req_vld ? {req_q[ADDR_W-1:OFF_B], {OFF_B{1'b0}}} : '0;

   // Round-robin only advances on refills; the tree also tracks hits.
   assign touch_way = fill_last ? victim_q : hit_way;
`ifdef CACHE_CTRL_PLRU_EN
   assign touch_en  = fill_last || lookup_hit;
`else
   assign touch_en  = fill_last;
`endif

   cache_ctrl_repl #(.WAYS(WAYS), .SETS(SETS)) u_repl (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (req_idx),
      .touch_way (touch_way),
      .touch_en  (touch_en),
      .valid     (valid_q[req_idx]),
      .victim    (repl_victim)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.inv)     state_d = ST_INVAL;
            else if (accept) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (!hit)              state_d = ST_MISS_REQ;
            else if (!bus.resp_rdy) state_d = ST_RESP;
            else if (accept)       state_d = ST_LOOKUP;
            else                   state_d = ST_IDLE;
         end
         ST_MISS_REQ: if (bus.mem_req_rdy) state_d = ST_REFILL;
         ST_REFILL:   if (fill_last)       state_d = ST_RESP;
         ST_RESP:     if (bus.resp_rdy)    state_d = ST_IDLE;
         ST_INVAL:    state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         req_q    <= '0;
         victim_q <= '0;
         cnt_q    <= '0;
         resp_q   <= '0;
         for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) req_q <= bus.uaddr;
         if ((state_q == ST_LOOKUP) && !hit) victim_q <= repl_victim;
         if (lookup_hit && !bus.resp_rdy) resp_q <= hit_word;
         // The victim goes invalid before its first beat lands, so a reset mid-line leaves no stale hit.
         if ((state_q == ST_MISS_REQ) && bus.mem_req_rdy) begin
            valid_q[req_idx][victim_q] <= 1'b0;
            cnt_q                      <= '0;
         end
         if (fill_beat) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == req_off) resp_q <= bus.mem_resp_data;
            if (&cnt_q) valid_q[req_idx][victim_q] <= 1'b1;
         end
         if (state_q == ST_INVAL) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_beat) data_q[req_idx][victim_q][cnt_q] <= bus.mem_resp_data;
      if (fill_last) tag_q[req_idx][victim_q] <= req_tag;
   end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - directed bench for cache_ctrl_nway; expectations follow CACHE_CTRL_PLRU_EN
module tb_cache_ctrl_nway;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   mreq_cnt;

   cache_ctrl_nway_if bus ();

   cache_ctrl_nway dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial mreq_cnt = 0;
   always @(posedge clk) if (bus.mem_req_vld && bus.mem_req_rdy) mreq_cnt++;

   localparam logic [31:0] A0 = 32'h0FF0_01F0;
   localparam logic [31:0] A1 = 32'h0AA0_01F0;
   localparam logic [31:0] A2 = 32'h0BB0_01F0;
   localparam logic [31:0] A3 = 32'h0000_01F0;
   localparam logic [31:0] A4 = 32'h0CC0_01F0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0FF0_01F0: return 32'hFF00_00FF;
         32'h0FF0_01F1: return 32'hF0F0_F0F0;
         32'h0FF0_01F2: return 32'h00FF_FF00;
         32'h0FF0_01F3: return 32'h00FF_00FF;
         default:       return {a[15:0], ~a[15:0]};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the controller idle; returns at a negedge, idle again.
   task automatic rd(input logic [31:0] a, input bit miss, input int hold, input string tag);
      int n;
      int m0;
      logic [31:0] line;
      line = {a[31:2], 2'b00};
      m0   = mreq_cnt;
      bus.resp_rdy = (hold == 0);
      bus.uvld     = 1'b1;
      bus.uaddr    = a;
      #1;
      n = 0;
      while (!bus.urdy && n < 50) begin
         @(negedge clk); #1; n++;
      end
      chk({tag, " accept_wait"}, 64'(n < 50), 64'd1);
      @(negedge clk);
      bus.uvld = 1'b0;
      #1;
      if (miss) begin
         chk({tag, " lookup_no_resp"}, bus.resp_vld, 1'b0);
         @(negedge clk); #1;
         chk({tag, " mem_req_vld"}, bus.mem_req_vld, 1'b1);
         chk({tag, " mem_req_addr"}, bus.mem_req_addr, line);
         chk({tag, " urdy_miss"}, bus.urdy, 1'b0);
         bus.mem_req_rdy = 1'b1;
         @(negedge clk);
         bus.mem_req_rdy = 1'b0;
         for (int i = 0; i < 4; i++) begin
            bus.mem_resp_vld  = 1'b1;
            bus.mem_resp_data = mem_word(line + 32'(i));
            @(negedge clk);
         end
         bus.mem_resp_vld = 1'b0;
         #1;
      end
      chk({tag, " resp_vld"}, bus.resp_vld, 1'b1);
      chk({tag, " resp_data"}, bus.resp_data, mem_word(a));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         chk({tag, " hold_vld"}, bus.resp_vld, 1'b1);
         chk({tag, " hold_data"}, bus.resp_data, mem_word(a));
         chk({tag, " hold_urdy"}, bus.urdy, 1'b0);
      end
      bus.resp_rdy = 1'b1;
      @(negedge clk); #1;
      chk({tag, " resp_single"}, bus.resp_vld, 1'b0);
      chk({tag, " mem_req_count"}, 64'(mreq_cnt - m0), miss ? 64'd1 : 64'd0);
   endtask

   function automatic logic [31:0] b2b_addr(input int k);
      logic [31:0] tags [4];
      tags[0] = A0; tags[1] = A1; tags[2] = A2; tags[3] = A3;
      return tags[k % 4] + 32'(k / 4);
   endfunction

   initial begin
      int m0;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.uvld = 1'b0; bus.uaddr = '0; bus.resp_rdy = 1'b1; bus.inv = 1'b0;
      bus.mem_req_rdy = 1'b0; bus.mem_resp_vld = 1'b0; bus.mem_resp_data = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst urdy", bus.urdy, 1'b1);
      chk("rst resp_vld", bus.resp_vld, 1'b0);
      chk("rst resp_data", bus.resp_data, 32'h0);
      chk("rst mem_req_vld", bus.mem_req_vld, 1'b0);
      chk("rst mem_req_addr", bus.mem_req_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      rd(A0, 1'b1, 0, "cold_miss");
      rd(32'h0FF0_01F2, 1'b0, 0, "cold_hit");
      rd(32'h0FF0_01F1, 1'b0, 5, "bp_hit");
      rd(32'h1234_5602, 1'b1, 5, "bp_fill");

      rd(A1, 1'b1, 0, "fill_aa");
      rd(A2, 1'b1, 0, "fill_bb");
      rd(A3, 1'b1, 0, "fill_00");

      m0 = mreq_cnt;
      bus.resp_rdy = 1'b1;
      bus.uvld     = 1'b1;
      bus.uaddr    = b2b_addr(0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #1;
         chk("b2b resp_vld", bus.resp_vld, 1'b1);
         chk("b2b resp_data", bus.resp_data, mem_word(b2b_addr(k)));
         chk("b2b urdy", bus.urdy, 1'b1);
         if (k < 15) bus.uaddr = b2b_addr(k + 1);
         else        bus.uvld  = 1'b0;
      end
      @(negedge clk); #1;
      chk("b2b mem_req_count", 64'(mreq_cnt - m0), 64'd0);

      rd(A4, 1'b1, 0, "evict_cc");
      rd(A0, 1'b1, 0, "victim_old_tag");
      rd(A4, 1'b0, 0, "keep_cc");
      rd(A3, 1'b0, 0, "keep_00");
`ifdef CACHE_CTRL_PLRU_EN
      rd(A1, 1'b0, 0, "plru_keep_aa");
      rd(A2, 1'b1, 0, "plru_evicted_bb");
`else
      rd(A2, 1'b0, 0, "rr_keep_bb");
      rd(A1, 1'b1, 0, "rr_evicted_aa");
`endif

      bus.inv   = 1'b1;
      bus.uvld  = 1'b1;
      bus.uaddr = A0;
      #1;
      chk("inv urdy_blocked", bus.urdy, 1'b0);
      @(negedge clk);
      bus.inv  = 1'b0;
      bus.uvld = 1'b0;
      #1;
      chk("inval urdy", bus.urdy, 1'b0);
      chk("inval resp_vld", bus.resp_vld, 1'b0);
      @(negedge clk); #1;
      chk("inval back_idle", bus.urdy, 1'b1);
      rd(A0, 1'b1, 0, "after_inv");

      bus.uvld  = 1'b1;
      bus.uaddr = 32'h5550_0041;
      @(negedge clk);
      bus.uvld = 1'b0;
      @(negedge clk); #1;
      chk("rstref mem_req_vld", bus.mem_req_vld, 1'b1);
      bus.mem_req_rdy = 1'b1;
      @(negedge clk);
      bus.mem_req_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.mem_resp_vld  = 1'b1;
         bus.mem_resp_data = mem_word(32'h5550_0040 + 32'(i));
         @(negedge clk);
      end
      bus.mem_resp_vld  = 1'b1;
      bus.mem_resp_data = mem_word(32'h5550_0042);
      rst_n = 1'b0;
      #1;
      chk("midrst urdy", bus.urdy, 1'b1);
      chk("midrst resp_vld", bus.resp_vld, 1'b0);
      chk("midrst resp_data", bus.resp_data, 32'h0);
      chk("midrst mem_req_vld", bus.mem_req_vld, 1'b0);
      chk("midrst mem_req_addr", bus.mem_req_addr, 32'h0);
      @(negedge clk);
      bus.mem_resp_vld = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      rd(32'h5550_0041, 1'b1, 0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
